// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-side fill arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic CLIENT_IC = 1'b0;
    localparam logic CLIENT_DC = 1'b1;

    localparam int DEF_WORDS_PER_BLOCK = 8;
    // Main memory is pipelined; the arbiter never counts latency, it just waits for returns.
    localparam int DEF_MEM_LATENCY     = 4;

endpackage

// File: rtl/arb_word_counter.sv
// Loadable/clearable up-counter with a terminal-count flag (all ones).
module arb_word_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = &count;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache/D-cache block fills onto a pipelined main memory and streams words back.
// Optional macro ROUND_ROBIN_EN: alternate grants on simultaneous misses instead of fixed D-cache priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ic_miss_detected,
    input  logic [15:0]      ic_addr_to_mem,
    output logic             ic_service,
    output logic             ic_data_valid,
    input  logic             dc_miss_detected,
    input  logic [15:0]      dc_addr_to_mem,
    output logic             dc_service,
    output logic             dc_data_valid,
    output logic [15:0]      data_from_mem,
    output logic [IDX_W-1:0] fill_word_idx,
    output logic             mem_en,
    output logic [15:0]      mem_addr,
    input  logic [15:0]      mem_data_out,
    input  logic             mem_data_valid
);

    localparam logic [15:0] BLOCK_MASK = ~16'(2 * WORDS_PER_BLOCK - 1);

    state_t            state;
    logic              grant;
    logic [15:0]       base;
    logic              issuing;
    logic              next_client;
    logic              start;
    logic              mem_ret;
    logic [IDX_W-1:0]  issue_cnt;
    logic [IDX_W-1:0]  ret_cnt;
    logic              issue_tc;
    logic              ret_tc;

`ifdef ROUND_ROBIN_EN
    logic last_grant;

    always_comb begin
        next_client = CLIENT_IC;
        if (ic_miss_detected && dc_miss_detected) begin
            next_client = (last_grant == CLIENT_IC) ? CLIENT_DC : CLIENT_IC;
        end else if (dc_miss_detected) begin
            next_client = CLIENT_DC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= CLIENT_IC;
        end else if (start) begin
            last_grant <= next_client;
        end
    end
`else
    assign next_client = dc_miss_detected ? CLIENT_DC : CLIENT_IC;
`endif

    assign start   = (state == IDLE) && (ic_miss_detected || dc_miss_detected);
    assign mem_ret = (state == FILL) && mem_data_valid;

    // Grant and block base are latched once; request lines are ignored for the rest of the fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= CLIENT_IC;
            base    <= '0;
            issuing <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        grant   <= next_client;
                        base    <= ((next_client == CLIENT_DC) ? dc_addr_to_mem
                                                               : ic_addr_to_mem) & BLOCK_MASK;
                        issuing <= 1'b1;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (issuing && issue_tc) begin
                        issuing <= 1'b0;
                    end
                    if (mem_ret && ret_tc) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    arb_word_counter #(.WIDTH(IDX_W)) u_issue_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .load     (1'b0),
        .load_val ('0),
        .en       (mem_en),
        .count    (issue_cnt),
        .tc       (issue_tc)
    );

    arb_word_counter #(.WIDTH(IDX_W)) u_ret_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .load     (1'b0),
        .load_val ('0),
        .en       (mem_ret),
        .count    (ret_cnt),
        .tc       (ret_tc)
    );

    assign mem_en   = (state == FILL) && issuing;
    assign mem_addr = mem_en ? (base | {{(15 - IDX_W){1'b0}}, issue_cnt, 1'b0}) : 16'h0000;

    assign ic_service    = (state == FILL) && (grant == CLIENT_IC);
    assign dc_service    = (state == FILL) && (grant == CLIENT_DC);
    assign ic_data_valid = mem_ret && (grant == CLIENT_IC);
    assign dc_data_valid = mem_ret && (grant == CLIENT_DC);
    assign data_from_mem = mem_ret ? mem_data_out : 16'h0000;
    assign fill_word_idx = mem_ret ? ret_cnt : '0;

endmodule
